// File: rtl/urv_trap_ctrl_pkg.sv
// Shared constants and types for the machine-mode trap controller:
// CSR addresses, status/enable bit positions, interrupt cause codes and FSM states.
package urv_trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam int CSR_MSTATUS_MIE  = 3;
    localparam int CSR_MSTATUS_MPIE = 7;
    localparam int CSR_MIE_MEIE     = 11;
    localparam int CSR_MIE_MTIE     = 7;

    localparam logic [3:0] CAUSE_IRQ_EXT   = 4'd11;
    localparam logic [3:0] CAUSE_IRQ_TIMER = 4'd7;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } trap_state_e;

    // Exception PCs are always word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/urv_trap_ctrl_sync_2ff.sv
// Per-bit two-flop synchroniser for asynchronous level inputs, async active-high reset.
module urv_trap_ctrl_sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture of the asynchronous levels
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_r <= '0;
            sync_r <= '0;
        end else begin
            meta_r <= d_i;
            sync_r <= meta_r;
        end
    end

    assign q_o = sync_r;

endmodule

// File: rtl/urv_trap_ctrl.sv
// Machine-mode trap/interrupt controller in the X stage: owns mstatus/mie/mip/mepc/mcause,
// arbitrates exception > interrupt > mret > CSR write and issues a registered PC redirect.
module urv_trap_ctrl
    import urv_trap_ctrl_pkg::*;
#(
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0008,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          IRQ_SYNC     = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        x_valid_i,
    input  logic        x_stall_i,
    input  logic        x_kill_i,
    input  logic [31:0] x_pc_i,
    input  logic        x_is_csr_i,
    input  logic [11:0] x_csr_sel_i,
    input  logic [31:0] x_csr_write_value_i,
    input  logic        x_exception_i,
    input  logic [3:0]  x_exception_cause_i,
    input  logic        x_is_mret_i,
    input  logic        irq_i,
    input  logic        timer_irq_i,
    output logic [31:0] csr_mstatus_o,
    output logic [31:0] csr_mie_o,
    output logic [31:0] csr_mip_o,
    output logic [31:0] csr_mepc_o,
    output logic [31:0] csr_mcause_o,
    output logic        x_redirect_o,
    output logic [31:0] x_redirect_pc_o
);

    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

    logic [1:0]  irq_sync_s;
    logic        meip_s, mtip_s;
    logic        commit_s, irq_pend_s;
    logic        exc_take_s, irq_take_s, mret_take_s, csr_wr_s, redirect_take_s;

    logic        mstatus_mie_r, mstatus_mpie_r, mie_meie_r, mie_mtie_r;
    logic [31:0] mepc_r;
    logic        mcause_int_r;
    logic [3:0]  mcause_code_r;
    logic        redirect_r;
    logic [31:0] redirect_pc_r;

    trap_state_e state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;

    generate
        if (IRQ_SYNC != 0) begin : g_sync
            urv_trap_ctrl_sync_2ff #(.WIDTH(2)) u_sync (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .d_i   ({irq_i, timer_irq_i}),
                .q_o   (irq_sync_s)
            );
        end else begin : g_nosync
            assign irq_sync_s = {irq_i, timer_irq_i};
        end
    endgenerate

    assign meip_s = irq_sync_s[1];
    assign mtip_s = irq_sync_s[0];

    assign commit_s   = x_valid_i & ~x_stall_i & ~x_kill_i;
    assign irq_pend_s = mstatus_mie_r & ((mie_meie_r & meip_s) | (mie_mtie_r & mtip_s));

    // Each lower-priority action is masked by every higher-priority one.
    assign exc_take_s      = commit_s & x_exception_i;
    assign irq_take_s      = commit_s & ~x_exception_i & irq_pend_s & (state_r == ST_RUN);
    assign mret_take_s     = commit_s & ~x_exception_i & ~irq_take_s & x_is_mret_i;
    assign csr_wr_s        = commit_s & ~x_exception_i & ~irq_take_s & ~x_is_mret_i & x_is_csr_i;
    assign redirect_take_s = exc_take_s | irq_take_s | mret_take_s;

    // CSR state: trap entry, mret restore, or software write
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mstatus_mie_r  <= 1'b0;
            mstatus_mpie_r <= 1'b0;
            mie_meie_r     <= 1'b0;
            mie_mtie_r     <= 1'b0;
            mepc_r         <= 32'h0000_0000;
            mcause_int_r   <= 1'b0;
            mcause_code_r  <= 4'h0;
        end else if (exc_take_s | irq_take_s) begin
            mstatus_mpie_r <= mstatus_mie_r;
            mstatus_mie_r  <= 1'b0;
            mepc_r         <= align_word(x_pc_i);
            mcause_int_r   <= irq_take_s;
            if (exc_take_s) begin
                mcause_code_r <= x_exception_cause_i;
            end else if (mie_meie_r & meip_s) begin
                mcause_code_r <= CAUSE_IRQ_EXT;
            end else begin
                mcause_code_r <= CAUSE_IRQ_TIMER;
            end
        end else if (mret_take_s) begin
            mstatus_mie_r  <= mstatus_mpie_r;
            mstatus_mpie_r <= 1'b1;
        end else if (csr_wr_s) begin
            case (x_csr_sel_i)
                CSR_MSTATUS: begin
                    mstatus_mie_r  <= x_csr_write_value_i[CSR_MSTATUS_MIE];
                    mstatus_mpie_r <= x_csr_write_value_i[CSR_MSTATUS_MPIE];
                end
                CSR_MIE: begin
                    mie_meie_r <= x_csr_write_value_i[CSR_MIE_MEIE];
                    mie_mtie_r <= x_csr_write_value_i[CSR_MIE_MTIE];
                end
                CSR_MEPC:   mepc_r <= align_word(x_csr_write_value_i);
                CSR_MCAUSE: begin
                    mcause_int_r  <= x_csr_write_value_i[31];
                    mcause_code_r <= x_csr_write_value_i[3:0];
                end
                default: ;
            endcase
        end
    end

    // Redirect pulse and sticky target
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            redirect_r    <= 1'b0;
            redirect_pc_r <= 32'h0000_0000;
        end else begin
            redirect_r <= redirect_take_s;
            if (exc_take_s | irq_take_s) begin
                redirect_pc_r <= TRAP_VECTOR;
            end else if (mret_take_s) begin
                redirect_pc_r <= mepc_r;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_RUN;
            cnt_r   <= 4'h0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // FSM next state: any redirect (re)starts the interrupt blackout window
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_RUN: begin
                if (redirect_take_s) begin
                    state_s = ST_FLUSH;
                    cnt_s   = FLUSH_RELOAD;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (redirect_take_s) begin
                    cnt_s = FLUSH_RELOAD;
                end else if (cnt_r == 4'h0) begin
                    state_s = ST_RUN;
                end else begin
                    cnt_s = cnt_r - 4'h1;
                end
            end
            default: begin
                state_s = ST_RUN;
                cnt_s   = 4'h0;
            end
        endcase
    end

    // CSR read views
    always_comb begin
        csr_mstatus_o = 32'h0000_0000;
        csr_mie_o     = 32'h0000_0000;
        csr_mip_o     = 32'h0000_0000;
        csr_mcause_o  = 32'h0000_0000;
        csr_mstatus_o[CSR_MSTATUS_MIE]  = mstatus_mie_r;
        csr_mstatus_o[CSR_MSTATUS_MPIE] = mstatus_mpie_r;
        csr_mie_o[CSR_MIE_MEIE]         = mie_meie_r;
        csr_mie_o[CSR_MIE_MTIE]         = mie_mtie_r;
        csr_mip_o[CSR_MIE_MEIE]         = meip_s;
        csr_mip_o[CSR_MIE_MTIE]         = mtip_s;
        csr_mcause_o[31]                = mcause_int_r;
        csr_mcause_o[3:0]               = mcause_code_r;
    end

    assign csr_mepc_o      = mepc_r;
    assign x_redirect_o    = redirect_r;
    assign x_redirect_pc_o = redirect_pc_r;

endmodule

// File: tb/tb_urv_trap_ctrl.sv
// Directed self-checking bench for urv_trap_ctrl (TRAP_VECTOR=8, FLUSH_CYCLES=2, IRQ_SYNC=1).
module tb_urv_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        x_valid, x_stall, x_kill, x_is_csr, x_exception, x_is_mret, irq, timer_irq;
    logic [31:0] x_pc, x_wval;
    logic [11:0] x_csr_sel;
    logic [3:0]  x_cause;
    logic [31:0] mstatus, mie, mip, mepc, mcause, redirect_pc;
    logic        redirect;

    int checks   = 0;
    int failures = 0;

    urv_trap_ctrl #(
        .TRAP_VECTOR  (32'h0000_0008),
        .FLUSH_CYCLES (2),
        .IRQ_SYNC     (1)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .x_valid_i           (x_valid),
        .x_stall_i           (x_stall),
        .x_kill_i            (x_kill),
        .x_pc_i              (x_pc),
        .x_is_csr_i          (x_is_csr),
        .x_csr_sel_i         (x_csr_sel),
        .x_csr_write_value_i (x_wval),
        .x_exception_i       (x_exception),
        .x_exception_cause_i (x_cause),
        .x_is_mret_i         (x_is_mret),
        .irq_i               (irq),
        .timer_irq_i         (timer_irq),
        .csr_mstatus_o       (mstatus),
        .csr_mie_o           (mie),
        .csr_mip_o           (mip),
        .csr_mepc_o          (mepc),
        .csr_mcause_o        (mcause),
        .x_redirect_o        (redirect),
        .x_redirect_pc_o     (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_x();
        x_valid = 1'b0; x_stall = 1'b0; x_kill = 1'b0; x_pc = 32'h0; x_is_csr = 1'b0;
        x_csr_sel = 12'h0; x_wval = 32'h0; x_exception = 1'b0; x_cause = 4'h0; x_is_mret = 1'b0;
    endtask

    task automatic idle(input int n);
        clear_x();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic csr_write(input logic [11:0] sel, input logic [31:0] val);
        clear_x();
        x_valid = 1'b1; x_is_csr = 1'b1; x_csr_sel = sel; x_wval = val; x_pc = 32'h0000_0100;
        tick();
        clear_x();
    endtask

    task automatic test_reset();
        rst = 1'b1; irq = 1'b0; timer_irq = 1'b0;
        clear_x();
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if (mstatus !== 32'h0) begin $display("FAIL reset_mstatus got=%h exp=%h", mstatus, 32'h0); failures++; end
        checks++; if (mie !== 32'h0) begin $display("FAIL reset_mie got=%h exp=%h", mie, 32'h0); failures++; end
        checks++; if (mip !== 32'h0) begin $display("FAIL reset_mip got=%h exp=%h", mip, 32'h0); failures++; end
        checks++; if (mepc !== 32'h0) begin $display("FAIL reset_mepc got=%h exp=%h", mepc, 32'h0); failures++; end
        checks++; if (mcause !== 32'h0) begin $display("FAIL reset_mcause got=%h exp=%h", mcause, 32'h0); failures++; end
        checks++; if (redirect !== 1'b0 || redirect_pc !== 32'h0) begin $display("FAIL reset_redirect got=%b/%h exp=0/0", redirect, redirect_pc); failures++; end
    endtask

    task automatic test_csr_write();
        csr_write(12'h300, 32'hFFFF_FFFF);
        checks++; if (mstatus !== 32'h0000_0088) begin $display("FAIL csr_mstatus got=%h exp=%h", mstatus, 32'h88); failures++; end
        csr_write(12'h341, 32'h0000_1003);
        checks++; if (mepc !== 32'h0000_1000) begin $display("FAIL csr_mepc got=%h exp=%h", mepc, 32'h1000); failures++; end
        csr_write(12'h344, 32'hFFFF_FFFF);
        checks++; if (mip !== 32'h0) begin $display("FAIL csr_mip_ro got=%h exp=%h", mip, 32'h0); failures++; end
        csr_write(12'h304, 32'hFFFF_FFFF);
        checks++; if (mie !== 32'h0000_0880) begin $display("FAIL csr_mie got=%h exp=%h", mie, 32'h880); failures++; end
        csr_write(12'h342, 32'hFFFF_FFFF);
        checks++; if (mcause !== 32'h8000_000F) begin $display("FAIL csr_mcause got=%h exp=%h", mcause, 32'h8000000F); failures++; end
        checks++; if (redirect !== 1'b0) begin $display("FAIL csr_no_redirect got=%b exp=0", redirect); failures++; end
        csr_write(12'h304, 32'h0000_0000);
        csr_write(12'h300, 32'h0000_0008);
        checks++; if (mstatus !== 32'h0000_0008 || mie !== 32'h0) begin $display("FAIL csr_restore got=%h/%h exp=8/0", mstatus, mie); failures++; end
    endtask

    task automatic test_exception();
        clear_x();
        x_valid = 1'b1; x_pc = 32'h0000_0200; x_exception = 1'b1; x_cause = 4'd2;
        tick();
        clear_x();
        checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h8) begin $display("FAIL exc_redirect got=%b/%h exp=1/00000008", redirect, redirect_pc); failures++; end
        checks++; if (mepc !== 32'h200) begin $display("FAIL exc_mepc got=%h exp=%h", mepc, 32'h200); failures++; end
        checks++; if (mcause !== 32'h2) begin $display("FAIL exc_mcause got=%h exp=%h", mcause, 32'h2); failures++; end
        checks++; if (mstatus !== 32'h80) begin $display("FAIL exc_mstatus got=%h exp=%h", mstatus, 32'h80); failures++; end
        tick();
        checks++; if (redirect !== 1'b0 || redirect_pc !== 32'h8) begin $display("FAIL exc_pulse got=%b/%h exp=0/00000008", redirect, redirect_pc); failures++; end
    endtask

    task automatic test_mret_flush();
        csr_write(12'h304, 32'h0000_0800);
        irq = 1'b1;
        idle(3);
        checks++; if (mip !== 32'h800) begin $display("FAIL mret_mip got=%h exp=%h", mip, 32'h800); failures++; end
        checks++; if (redirect !== 1'b0) begin $display("FAIL mret_masked_irq got=%b exp=0", redirect); failures++; end
        x_valid = 1'b1; x_is_mret = 1'b1; x_pc = 32'h0000_0300;
        tick();
        clear_x();
        checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h200) begin $display("FAIL mret_redirect got=%b/%h exp=1/00000200", redirect, redirect_pc); failures++; end
        checks++; if (mstatus !== 32'h88) begin $display("FAIL mret_mstatus got=%h exp=%h", mstatus, 32'h88); failures++; end
        x_valid = 1'b1; x_pc = 32'h0000_0400;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (redirect !== 1'b0) begin $display("FAIL flush_hold%0d got=%b exp=0", i, redirect); failures++; end
        end
        tick();
        clear_x();
        checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h8) begin $display("FAIL flush_irq_taken got=%b/%h exp=1/00000008", redirect, redirect_pc); failures++; end
        checks++; if (mcause !== 32'h8000_000B || mepc !== 32'h400) begin $display("FAIL flush_irq_cause got=%h/%h exp=8000000b/00000400", mcause, mepc); failures++; end
        checks++; if (mstatus !== 32'h80) begin $display("FAIL flush_irq_mstatus got=%h exp=%h", mstatus, 32'h80); failures++; end
    endtask

    task automatic test_irq_latency();
        irq = 1'b0; timer_irq = 1'b0;
        idle(4);
        csr_write(12'h300, 32'h0000_0008);
        csr_write(12'h304, 32'h0000_0880);
        x_valid = 1'b1; x_pc = 32'h0000_0700;
        irq = 1'b1; timer_irq = 1'b1;
        tick();
        checks++; if (redirect !== 1'b0) begin $display("FAIL irq_lat1 got=%b exp=0", redirect); failures++; end
        tick();
        checks++; if (redirect !== 1'b0 || mip !== 32'h880) begin $display("FAIL irq_lat2 got=%b/%h exp=0/00000880", redirect, mip); failures++; end
        tick();
        clear_x();
        checks++; if (redirect !== 1'b1 || mcause !== 32'h8000_000B) begin $display("FAIL irq_ext_beats_timer got=%b/%h exp=1/8000000b", redirect, mcause); failures++; end
        checks++; if (mepc !== 32'h700) begin $display("FAIL irq_mepc got=%h exp=%h", mepc, 32'h700); failures++; end
    endtask

    task automatic test_priority();
        csr_write(12'h300, 32'h0000_0008);
        checks++; if (mstatus !== 32'h8) begin $display("FAIL flush_csr_write got=%h exp=%h", mstatus, 32'h8); failures++; end
        idle(1);
        x_valid = 1'b1; x_pc = 32'h0000_0503; x_exception = 1'b1; x_cause = 4'd5;
        x_is_csr = 1'b1; x_csr_sel = 12'h304; x_wval = 32'h0;
        tick();
        clear_x();
        checks++; if (redirect !== 1'b1 || mcause !== 32'h5) begin $display("FAIL prio_exc got=%b/%h exp=1/00000005", redirect, mcause); failures++; end
        checks++; if (mie !== 32'h880 || mepc !== 32'h500) begin $display("FAIL prio_side got=%h/%h exp=00000880/00000500", mie, mepc); failures++; end
        idle(2);
        x_valid = 1'b1; x_stall = 1'b1; x_pc = 32'h0000_0600; x_exception = 1'b1; x_cause = 4'd3;
        x_is_csr = 1'b1; x_csr_sel = 12'h300; x_wval = 32'hFFFF_FFFF;
        tick();
        x_stall = 1'b0; x_kill = 1'b1;
        tick();
        clear_x();
        checks++; if (redirect !== 1'b0 || mepc !== 32'h500 || mcause !== 32'h5 || mstatus !== 32'h80) begin
            $display("FAIL stall_kill got=%b/%h/%h/%h exp=0/00000500/00000005/00000080", redirect, mepc, mcause, mstatus); failures++; end
    endtask

    task automatic test_reset_mid_flush();
        irq = 1'b0; timer_irq = 1'b0;
        x_valid = 1'b1; x_pc = 32'h0000_0800; x_exception = 1'b1; x_cause = 4'd4;
        tick();
        clear_x();
        checks++; if (redirect !== 1'b1) begin $display("FAIL mid_flush_setup got=%b exp=1", redirect); failures++; end
        #2 rst = 1'b1;
        #1;
        checks++; if (redirect !== 1'b0 || redirect_pc !== 32'h0 || mepc !== 32'h0 || mcause !== 32'h0 || mstatus !== 32'h0 || mie !== 32'h0) begin
            $display("FAIL async_reset got=%b/%h/%h/%h exp=0/0/0/0", redirect, redirect_pc, mepc, mcause); failures++; end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (dut.state_r !== 1'b0 || redirect !== 1'b0 || mstatus !== 32'h0) begin $display("FAIL reset_run got=%b/%b exp=0/0", dut.state_r, redirect); failures++; end
    endtask

    initial begin
        test_reset();
        test_csr_write();
        test_exception();
        test_mret_flush();
        test_irq_latency();
        test_priority();
        test_reset_mid_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
